// File: rtl/seq_alu.sv
// Multi-cycle ALU: registered single-cycle ops, shift-add MUL, restoring DIVU/REMU.
// Optional divider built when SEQ_ALU_DIV_EN is defined; otherwise 1010/1011 act as unknown ops.
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic             zero,
  output logic             div0
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpMul  = 4'b1001;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpSra  = 4'b1101;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OpDivu = 4'b1010;
  localparam logic [3:0] OpRemu = 4'b1011;
`endif

  localparam logic [SHAMT_W-1:0] CntLast = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMul,
`ifdef SEQ_ALU_DIV_EN
    StDiv,
`endif
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_sum;
  logic [SHAMT_W-1:0] shamt;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               isrem_q, isrem_d;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   div_res;
`endif

  assign shamt = input2[SHAMT_W-1:0];

  // Single-cycle results are taken straight from the inputs at the start edge.
  always_comb begin
    alu_res = '0;
    case (ALUControl)
      OpAnd:   alu_res = input1 & input2;
      OpOr:    alu_res = input1 | input2;
      OpAdd:   alu_res = input1 + input2;
      OpSub:   alu_res = input1 - input2;
      OpNor:   alu_res = ~(input1 | input2);
      OpXor:   alu_res = input1 ^ input2;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, input1 < input2};
      OpSll:   alu_res = input1 << shamt;
      OpSrl:   alu_res = input1 >> shamt;
      OpSra:   alu_res = $unsigned($signed(input1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_ALU_DIV_EN
  // A zero divisor always "fits": quotient fills with ones and the remainder
  // collects the dividend, which is exactly the required divide-by-zero result.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign fits      = ~rem_diff[WIDTH];
  assign rem_next  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], fits};
  assign div_res   = isrem_q ? rem_next : quo_next;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    zero_d   = zero_q;
    div0_d   = div0_q;
`ifdef SEQ_ALU_DIV_EN
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    isrem_d  = isrem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (ALUControl == OpMul) begin
            state_d  = StMul;
            cnt_d    = '0;
            mcand_d  = input1;
            mplier_d = input2;
            acc_d    = '0;
`ifdef SEQ_ALU_DIV_EN
          end else if (ALUControl == OpDivu || ALUControl == OpRemu) begin
            state_d = StDiv;
            cnt_d   = '0;
            dvsr_d  = input2;
            quo_d   = input1;
            rem_d   = '0;
            isrem_d = ALUControl[0];
`endif
          end else begin
            state_d = StDone;
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            div0_d  = 1'b0;
          end
        end
      end
      StMul: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHAMT_W'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          out_d   = acc_sum;
          zero_d  = (acc_sum == '0);
          div0_d  = 1'b0;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      StDiv: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          out_d   = div_res;
          zero_d  = (div_res == '0);
          div0_d  = (dvsr_q == '0);
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
    end
  end

`ifdef SEQ_ALU_DIV_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      isrem_q <= 1'b0;
    end else begin
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      isrem_q <= isrem_d;
    end
  end

  assign busy = (state_q == StMul) || (state_q == StDiv);
`else
  assign busy = (state_q == StMul);
`endif

  assign done   = (state_q == StDone);
  assign ALUOut = out_q;
  assign zero   = zero_q;
  assign div0   = div0_q;

endmodule
